// File: rtl/cle.sv
// cle: labels 8-connected objects of a 32x32 ROM image into a 1024x8 SRAM.
// Optional CLE_COMPACT_LABEL_EN renumbers final labels 1..N in raster order.
module cle (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rom_q,
    output logic [6:0] rom_a,
    input  logic [7:0] sram_q,
    output logic [9:0] sram_a,
    output logic [7:0] sram_d,
    output logic       sram_wen,
    output logic       finish
);
    typedef enum logic [2:0] {IDLE, PASS1, FLATTEN, PASS2, DONE} state_t;
    state_t state, nxt;
    logic [11:0] cnt;
    logic [6:0] nl;
    logic [7:0] sr;
    logic [5:0] par [64];
    logic [5:0] rb [32];
    logic [5:0] w_r, nw_r, hold;
    logic [9:0] p;
    logic [4:0] c;
    logic [5:0] rw, rnw, rn, rne, lo, hi, lab, fi, q_root, q_val;
`ifdef CLE_COMPACT_LABEL_EN
    logic [5:0] cmap [64];
    logic [5:0] ccnt;
`endif

    function automatic logic [5:0] mn(input logic [5:0] a, input logic [5:0] b);
        return a == 6'd0 ? b : b == 6'd0 ? a : (a < b ? a : b);
    endfunction

    function automatic logic [5:0] mx(input logic [5:0] a, input logic [5:0] b);
        return a > b ? a : b;
    endfunction

    // Table is kept flat at all times, so a single lookup yields a root.
    assign p = cnt[9:0] - 10'd2;
    assign c = p[4:0];
    assign rw = c == 5'd0 ? 6'd0 : par[w_r];
    assign rnw = c == 5'd0 ? 6'd0 : par[nw_r];
    assign rn = par[rb[c]];
    assign rne = c == 5'd31 ? 6'd0 : par[rb[c + 5'd1]];
    assign lo = mn(mn(rw, rnw), mn(rn, rne));
    assign hi = mx(mx(rw, rnw), mx(rn, rne));
    assign lab = !sr[7] ? 6'd0 : lo != 6'd0 ? lo : nl[6] ? 6'd63 : nl[5:0];
    assign fi = cnt[5:0] + 6'd1;
    assign q_root = par[sram_q[5:0]];
`ifdef CLE_COMPACT_LABEL_EN
    assign q_val = sram_q == 8'd0 ? 6'd0 : cmap[q_root];
`else
    assign q_val = sram_q == 8'd0 ? 6'd0 : q_root;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = PASS1;
            PASS1:   if (cnt == 12'd1025) nxt = FLATTEN;
            FLATTEN: if (cnt == 12'd62) nxt = PASS2;
            PASS2:   if (cnt == 12'd2049) nxt = DONE;
            default: nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            nl <= 7'd1;
            sr <= '0;
            w_r <= '0;
            nw_r <= '0;
            hold <= '0;
            rom_a <= '0;
            sram_a <= '0;
            sram_d <= '0;
            sram_wen <= 1'b1;
            finish <= 1'b0;
            for (int i = 0; i < 64; i++) par[i] <= 6'(i);
            for (int i = 0; i < 32; i++) rb[i] <= '0;
`ifdef CLE_COMPACT_LABEL_EN
            ccnt <= 6'd1;
`endif
        end else begin
            cnt <= nxt != state ? 12'd0 : cnt + 12'd1;
            case (state)
                PASS1: begin
                    // Byte k is requested in cycle 8k and consumed from cycle 8k+2.
                    if (cnt < 12'd1023) rom_a <= 7'((cnt + 12'd1) >> 3);
                    sr <= cnt[2:0] == 3'd1 ? rom_q : sr << 1;
                    if (cnt >= 12'd2) begin
                        rb[c] <= lab;
                        nw_r <= rb[c];
                        w_r <= lab;
                        sram_a <= p;
                        sram_d <= {2'b0, lab};
                        sram_wen <= 1'b0;
                        if (sr[7] && lo == 6'd0 && !nl[6]) nl <= nl + 7'd1;
                        if (sr[7] && lo != 6'd0 && lo != hi)
                            for (int i = 0; i < 64; i++)
                                if (par[i] == hi) par[i] <= lo;
                    end
                end
                FLATTEN: begin
                    sram_wen <= 1'b1;
                    par[fi] <= par[par[fi]];
`ifdef CLE_COMPACT_LABEL_EN
                    if (par[fi] == fi && {1'b0, fi} < nl) begin
                        cmap[fi] <= ccnt;
                        ccnt <= ccnt + 6'd1;
                    end
`endif
                end
                PASS2: begin
                    // Reads of pixel j overlap the write-back of pixel j-1.
                    if (!cnt[0]) begin
                        if (!cnt[11]) sram_a <= cnt[10:1];
                        sram_wen <= 1'b1;
                        hold <= q_val;
                    end else begin
                        sram_a <= cnt[10:1] - 10'd1;
                        sram_d <= {2'b0, hold};
                        sram_wen <= hold == 6'd0 || cnt == 12'd1;
                    end
                end
                DONE: begin
                    sram_wen <= 1'b1;
                    finish <= sram_wen;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cle.sv
// tb_cle: drives cle with ROM/SRAM models and checks labels against a flood-fill reference.
module tb_cle;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scramble = 1'b0;
    logic [7:0] rom_q, sram_q, sram_d;
    logic [6:0] rom_a;
    logic [9:0] sram_a;
    logic sram_wen, finish;
    logic [7:0] rom [128];
    logic [7:0] mem [1024];
    logic [7:0] exp_mem [1024];
    logic [1023:0] im;
    int ncmp = 0;
    int nerr = 0;

    cle dut (
        .clk(clk), .reset(reset), .rom_q(rom_q), .rom_a(rom_a), .sram_q(sram_q),
        .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .finish(finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_q <= rom[rom_a];
        if (scramble) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'($urandom);
        end else if (!sram_wen) mem[sram_a] <= sram_d;
        else sram_q <= mem[sram_a];
    end

    task automatic chk(input string tag, input int obs, input int expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic calc(input logic [1023:0] img);
        int comp [1024];
        int root [1024];
        int q [$];
        int k = 0;
        int starts = 0;
        int x, rr, cc, r, c;
        bit st;
        for (int i = 0; i < 1024; i++) begin
            comp[i] = 0;
            root[i] = 0;
        end
        for (int i = 0; i < 1024; i++)
            if (img[i] && comp[i] == 0) begin
                k++;
                comp[i] = k;
                q.push_back(i);
                while (q.size() > 0) begin
                    x = q.pop_front();
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            rr = x / 32 + dr;
                            cc = x % 32 + dc;
                            if (rr >= 0 && rr < 32 && cc >= 0 && cc < 32)
                                if (img[rr*32+cc] && comp[rr*32+cc] == 0) begin
                                    comp[rr*32+cc] = k;
                                    q.push_back(rr*32+cc);
                                end
                        end
                end
            end
        for (int i = 0; i < 1024; i++) begin
            exp_mem[i] = 8'd0;
            if (img[i]) begin
                r = i / 32;
                c = i % 32;
                st = 1'b1;
                if (c > 0 && img[i-1]) st = 1'b0;
                if (r > 0 && c > 0 && img[i-33]) st = 1'b0;
                if (r > 0 && img[i-32]) st = 1'b0;
                if (r > 0 && c < 31 && img[i-31]) st = 1'b0;
                if (st) starts++;
                if (root[comp[i]] == 0) root[comp[i]] = starts;
`ifdef CLE_COMPACT_LABEL_EN
                exp_mem[i] = 8'(comp[i]);
`else
                exp_mem[i] = 8'(root[comp[i]]);
`endif
            end
        end
    endtask

    task automatic run(input logic [1023:0] img, input string tag, input bit scr, input int abort);
        int n = 0;
        int bad = 0;
        int fb = 0;
        logic [7:0] b;
        reset = 1'b1;
        for (int a = 0; a < 128; a++) begin
            for (int j = 0; j < 8; j++) b[7-j] = img[a*8+j];
            rom[a] = b;
        end
        @(negedge clk);
        chk({tag, "_rst_finish"}, int'(finish), 0);
        scramble = scr;
        @(negedge clk);
        scramble = 1'b0;
        chk({tag, "_rst_rom_a"}, int'(rom_a), 0);
        chk({tag, "_rst_sram_a"}, int'(sram_a), 0);
        chk({tag, "_rst_sram_d"}, int'(sram_d), 0);
        chk({tag, "_rst_wen"}, int'(sram_wen), 1);
        reset = 1'b0;
        if (abort > 0) begin
            repeat (abort) @(negedge clk);
            chk({tag, "_mid_finish"}, int'(finish), 0);
            return;
        end
        while (finish !== 1'b1 && n < 3300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finish_bound"}, int'(finish), 1);
        calc(img);
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== exp_mem[i]) begin
                if (bad == 0) fb = i;
                bad++;
            end
        ncmp++;
        assert (bad == 0) else begin
            nerr++;
            $error("FAIL %s_labels: %0d words wrong, first at %0d observed %0d expected %0d",
                   tag, bad, fb, mem[fb], exp_mem[fb]);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_finish_hold"}, int'(finish), 1);
        chk({tag, "_done_wen"}, int'(sram_wen), 1);
    endtask

    function automatic logic [1023:0] rect(input logic [1023:0] img, input int r0, input int c0,
                                           input int h, input int w);
        logic [1023:0] o = img;
        for (int r = r0; r < r0 + h && r < 32; r++)
            for (int c = c0; c < c0 + w && c < 32; c++) o[r*32+c] = 1'b1;
        return o;
    endfunction

    initial begin
        im = '0;
        run(im, "zero", 1'b1, 0);
        im = '0;
        im[0] = 1'b1;
        run(im, "single", 1'b1, 0);
        im = '0;
        for (int r = 0; r < 32; r++) im[r*33] = 1'b1;
        run(im, "diag", 1'b1, 0);
        im = rect('0, 2, 5, 19, 1);
        im = rect(im, 2, 15, 19, 1);
        im = rect(im, 20, 5, 1, 11);
        run(im, "ushape", 1'b1, 0);
        im = '0;
        for (int k = 0; k < 5; k++) im = rect(im, 20, 2 + 4*k, 10, 1);
        im = rect(im, 29, 2, 1, 17);
        run(im, "comb", 1'b1, 0);
        im = rect('0, 1, 1, 4, 6);
        im = rect(im, 8, 2, 1, 9);
        im = rect(im, 14, 2, 1, 9);
        im = rect(im, 8, 2, 7, 1);
        im = rect(im, 8, 10, 7, 1);
        for (int r = 0; r < 10; r++) im[r*32+30-r] = 1'b1;
        im = rect(im, 18, 20, 11, 1);
        im = rect(im, 28, 20, 1, 9);
        im[30*32+2] = 1'b1;
        run(im, "five", 1'b1, 0);
        for (int t = 0; t < 4; t++) begin
            im = '0;
            for (int k = 0; k < 7; k++)
                im = rect(im, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                          int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
            run(im, $sformatf("rand%0d", t), 1'b1, 0);
        end
        im = rect('0, 3, 3, 8, 8);
        run(im, "abort", 1'b1, 1800);
        im = '0;
        for (int r = 0; r < 32; r += 3) im = rect(im, r, (r * 7) % 29, 2, 3);
        run(im, "after_abort", 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
